// File: rtl/score_pkg.sv
// Shared types and helpers for the score overlay.
//   conv_state_t : BCD conversion FSM states
//   bcd_digit_t  : one packed BCD nibble
//   digit_pix()  : pixels per digit sprite, folds at elaboration
package score_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } conv_state_t;

    typedef logic [3:0] bcd_digit_t;

    function automatic int unsigned digit_pix(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

endpackage

// File: rtl/bcd_seq_conv.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : begin a conversion (ignored while busy)
//   bin        : binary value, snapshotted on an accepted start
//   busy       : conversion in progress
//   done       : high for the single LOAD cycle; bcd is final while done=1
//   bcd        : BCD shift register, NUM_DIGITS nibbles, MS nibble on top
module bcd_seq_conv
    import score_pkg::*;
#(
    parameter int unsigned SCORE_W    = 14,
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [SCORE_W-1:0]      bin,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd
);

    localparam int unsigned BCD_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = $clog2(SCORE_W + 1);

    conv_state_t        state_q, state_d;
    logic [SCORE_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]   acc_q, acc_d, adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_d, done_d;

    assign bcd = acc_q;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Next-state, datapath and outputs
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        busy_d  = busy;
        done_d  = 1'b0;
        adj     = acc_q;

        // add-3 correction on every nibble >= 5 before the shift
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = bin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = {adj[BCD_W-2:0], bin_q[SCORE_W-1]};
                bin_d = {bin_q[SCORE_W-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(SCORE_W - 1)) begin
                    done_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/score_display_v2.sv
// Score keeper and multi-digit sprite overlay.
//   Clk, Reset   : clock, synchronous active-low reset
//   add1, add2   : +1 point pulses; clear zeroes the score (priority)
//   frame_start  : vblank pulse, starts a BCD conversion of the score
//   DrawX, DrawY : current pixel
//   is_score     : registered hit flag for a visible digit pixel
//   score_addr   : registered digit-sprite ROM address (0 on miss)
//   score_value  : running score; high_score : best since reset
//   busy         : BCD conversion in progress
module score_display_v2
    import score_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCORE_W    = 14,
    parameter int unsigned SCORE_MAX  = 9999,
    parameter int unsigned DIGIT_W    = 30,
    parameter int unsigned DIGIT_H    = 40,
    parameter int unsigned GAP        = 4,
    parameter int unsigned ORIGIN_X   = 260,
    parameter int unsigned ORIGIN_Y   = 40,
    parameter int unsigned ROM_AW     = 19
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               add1,
    input  logic               add2,
    input  logic               clear,
    input  logic               frame_start,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    output logic               is_score,
    output logic [ROM_AW-1:0]  score_addr,
    output logic [SCORE_W-1:0] score_value,
    output logic [SCORE_W-1:0] high_score,
    output logic               busy
);

    localparam int unsigned BCD_W     = 4 * NUM_DIGITS;
    localparam int unsigned SUM_W     = SCORE_W + 1;
    localparam int unsigned CW        = 11;
    localparam int unsigned PITCH     = DIGIT_W + GAP;
    localparam int unsigned DIGIT_PIX = digit_pix(DIGIT_W, DIGIT_H);

    logic [SUM_W-1:0]   sum;
    logic [SCORE_W-1:0] score_d, high_d;
    logic [BCD_W-1:0]   shown, conv_bcd;
    logic               conv_done;

    logic [CW-1:0]      rel_x, rel_y, sel_dx;
    logic               in_x, in_y, lead_zero, hit_d;
    bcd_digit_t         dig, sel_d;
    logic [ROM_AW-1:0]  addr_d;

    bcd_seq_conv #(
        .SCORE_W    (SCORE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .clk   (Clk),
        .rst_n (Reset),
        .start (frame_start),
        .bin   (score_value),
        .busy  (busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Saturating score with clear priority; high score tracks the next score
    always_comb begin
        sum = SUM_W'(score_value) + SUM_W'(add1) + SUM_W'(add2);
        if (clear) begin
            score_d = '0;
        end else if (sum > SUM_W'(SCORE_MAX)) begin
            score_d = SCORE_W'(SCORE_MAX);
        end else begin
            score_d = sum[SCORE_W-1:0];
        end
        high_d = (score_d > high_score) ? score_d : high_score;
    end

    // Cell hit test with leading-zero suppression (digit 0 is leftmost)
    always_comb begin
        in_x      = CW'(DrawX) >= CW'(ORIGIN_X);
        in_y      = (CW'(DrawY) >= CW'(ORIGIN_Y)) && (CW'(DrawY) < CW'(ORIGIN_Y + DIGIT_H));
        rel_x     = CW'(DrawX) - CW'(ORIGIN_X);
        rel_y     = CW'(DrawY) - CW'(ORIGIN_Y);
        lead_zero = 1'b1;
        hit_d     = 1'b0;
        dig       = '0;
        sel_d     = '0;
        sel_dx    = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            dig       = shown[4*(int'(NUM_DIGITS) - 1 - i) +: 4];
            lead_zero = lead_zero && (dig == 4'd0);
            if (in_x && in_y
                && rel_x >= CW'(i * int'(PITCH))
                && rel_x <  CW'(i * int'(PITCH) + int'(DIGIT_W))
                && !(lead_zero && i != int'(NUM_DIGITS) - 1)) begin
                hit_d  = 1'b1;
                sel_d  = dig;
                sel_dx = rel_x - CW'(i * int'(PITCH));
            end
        end
        addr_d = hit_d ? (ROM_AW'(sel_d) * ROM_AW'(DIGIT_PIX)
                          + ROM_AW'(rel_y) * ROM_AW'(DIGIT_W)
                          + ROM_AW'(sel_dx))
                       : '0;
    end

    // Score, shown digits and pixel output registers
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            score_value <= '0;
            high_score  <= '0;
            shown       <= '0;
            is_score    <= 1'b0;
            score_addr  <= '0;
        end else begin
            score_value <= score_d;
            high_score  <= high_d;
            if (conv_done) begin
                shown <= conv_bcd;
            end
            is_score    <= hit_d;
            score_addr  <= addr_d;
        end
    end

endmodule

// File: doc/score_display_v2.md
Name: score_display_v2

Overview:
- Parametrised successor to the two-digit score overlay.
- Owns the running score itself: increments on per-player point pulses, saturates at a configurable maximum, and tracks a high score.
- Converts the score to BCD sequentially, once per frame.
- Renders NUM_DIGITS digits with leading-zero suppression. Output is a digit-sprite ROM address plus a pixel-hit flag, consumed by the colour mapper alongside the bird/pipe layers.

Parameters:
- NUM_DIGITS, 4: displayed digit count, leftmost digit most significant.
- SCORE_W, 14: score and high-score register width.
- SCORE_MAX, 9999: saturation ceiling. Must be ≤ 10^NUM_DIGITS−1 and ≤ 2^SCORE_W−1.
- DIGIT_W, 30: sprite width in pixels.
- DIGIT_H, 40: sprite height in pixels.
- GAP, 4: blank pixels between adjacent digits.
- ORIGIN_X, 260: left x of the leftmost digit cell.
- ORIGIN_Y, 40: top y of the digit row.
- ROM_AW, 19: sprite ROM address width.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-low reset.
- add1  in  1  player-1 point pulse, one cycle, +1.
- add2  in  1  player-2 point pulse, one cycle, +1.
- clear  in  1  new-game pulse: zero the score.
- frame_start  in  1  one-cycle pulse at vblank start; triggers BCD conversion.
- DrawX  in  10  current pixel x.
- DrawY  in  10  current pixel y.
- is_score  out  1  registered: pixel lies in a visible digit cell.
- score_addr  out  ROM_AW  registered sprite ROM address.
- score_value  out  SCORE_W  current binary score.
- high_score  out  SCORE_W  best score since reset.
- busy  out  1  BCD conversion in progress.

Behaviour:
- **Reset** (Clk edge with Reset=0) clears:
  - score_value, high_score, and the shown-digit registers (all 0);
  - is_score=0, score_addr=0, busy=0;
  - FSM to IDLE.
  - Reset mid-conversion aborts the conversion with no partial update.
- **Score update, per cycle**, priority clear > add:
  - clear=1: score := 0; add pulses in the same cycle are dropped.
  - Otherwise score := min(score + add1 + add2, SCORE_MAX). Both pulses in one cycle give +2.
  - At SCORE_MAX, further adds are ignored.
- **High score:** high_score := max(high_score, next score), updated in the same cycle as the score. It is never cleared by clear.
- **Conversion FSM** (IDLE → SHIFT → LOAD → IDLE):
  - IDLE: on frame_start, snapshot score_value, load the BCD shift register with 0, set busy=1, go to SHIFT.
  - SHIFT: one double-dabble step per cycle: add 3 to each nibble ≥ 5, then shift in the next MSB. Exactly SCORE_W cycles, then go to LOAD.
  - LOAD: copy the BCD nibbles into the shown-digit registers, busy=0, return to IDLE.
  - Total latency is SCORE_W+2 cycles from frame_start to new digits being visible.
  - frame_start while busy is ignored.
  - Score changes during conversion do not affect the snapshot; they appear at the next frame.
- **Pixel path**, registered, 1-cycle latency from DrawX/DrawY:
  - Digit i (0 = leftmost) has cell x ∈ [ORIGIN_X + i·(DIGIT_W+GAP), +DIGIT_W) and y ∈ [ORIGIN_Y, ORIGIN_Y+DIGIT_H).
  - Compute dx and dy as unsigned offsets. Coordinates left of or above the origin must not wrap into a hit.
  - Hit requires the pixel to be inside a cell, not in a gap, and the digit not suppressed.
  - Suppression: digit i is suppressed if it and all digits to its left are 0. The rightmost digit is never suppressed, so score 0 shows "0".
  - On a hit: is_score=1 and score_addr = d·(DIGIT_W·DIGIT_H) + dy·DIGIT_W + dx, where d is the shown BCD value.
  - On a miss: is_score=0 and score_addr=0.
  - Multiplications by constants fold at elaboration; no runtime multiplier by variable operands except d.

Decomposition:
- Package score_pkg:
  - fsm state enum (IDLE, SHIFT, LOAD);
  - typedef bcd_digit_t (logic [3:0]);
  - localparam DIGIT_PIX = DIGIT_W·DIGIT_H helper function.
- Sub-module bcd_seq_conv (parametrised SCORE_W, NUM_DIGITS):
  - implements the FSM and shift register;
  - interface: start, bin, busy, done, bcd.
- The top holds the score/high-score registers and the pixel path.

Test Plan:
- Reset low 2 cycles mid-SHIFT with score 57 → all outputs 0; the next frame_start after release with score 0 shows only the rightmost digit "0".
- 123 add1 pulses, then frame_start, wait 16 cycles; scan the row at DrawY=50 → is_score is high only in cells 1..3. Cell 1 at DrawX=294, y=50 gives score_addr = 1·1200 + 10·30 + 0 = 1500, seen one cycle after the pixel.
- add1 and add2 together 3 times → score_value=6. Then clear and add1 together → score_value=0 and high_score=6.
- Preload 9998, pulse add1+add2 together → score_value=9999; a further add1 leaves it at 9999.
- frame_start at score 40, then add1 and a second frame_start during busy → shown digits "40" (second pulse ignored). The next accepted frame_start shows "41".
- DrawX in the gap between cells (ORIGIN_X+30..33) and DrawX=ORIGIN_X−1 → is_score=0, score_addr=0.
